// File: rtl/two_source_arbiter.sv
// Two-source valid/ready arbiter feeding a single registered output stage.
// Round-robin or fixed-priority (A first) selection, with a per-source
// acceptance counter. out_src selects the downstream 2:1 word mux.
module two_source_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16,
  parameter bit          RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_src,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  // Source index of the most recent grant: 0 = A, 1 = B.
  logic last_grant;
  logic load;
  logic grant_a;
  logic grant_b;

  // Output stage can take a new word when empty or being drained this cycle.
  always_comb begin
    load = !out_valid || out_ready;
  end

  // Grant selection; only meaningful while the output stage can load.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (load) begin
      if (a_valid && b_valid) begin
        if (RR_EN) begin
          // Serve whichever source was not served last.
          grant_a = last_grant;
          grant_b = !last_grant;
        end else begin
          grant_a = 1'b1;
        end
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  // Readies are the grants themselves: combinational through out_ready.
  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Output register and fairness tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_src    <= 1'b0;
      last_grant <= 1'b1;
    end else if (grant_a || grant_b) begin
      out_data   <= grant_b ? b_data : a_data;
      out_src    <= grant_b;
      out_valid  <= 1'b1;
      last_grant <= grant_b;
    end else if (load) begin
      out_valid  <= 1'b0;
    end
  end

  // Per-source acceptance counters, free-running modulo 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (grant_a) cnt_a <= cnt_a + CNT_W'(1);
      if (grant_b) cnt_b <= cnt_b + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_two_source_arbiter.sv
// Bench for two_source_arbiter: a round-robin instance (index 0) and a
// fixed-priority instance (index 1) share stimulus; a behavioural model
// predicts each one.
module tb_two_source_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a_data = '0;
  logic        a_valid = 1'b0;
  logic [31:0] b_data = '0;
  logic        b_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        a_rdy [2];
  logic        b_rdy [2];
  logic [31:0] o_data [2];
  logic        o_valid [2];
  logic        o_src [2];
  logic [15:0] c_a [2];
  logic [15:0] c_b [2];

  int passed = 0;
  int total  = 0;

  // Model state per instance.
  logic [31:0] m_data [2];
  bit          m_valid [2];
  bit          m_src [2];
  bit          m_last [2];
  int unsigned m_cnt_a [2];
  int unsigned m_cnt_b [2];

  always #5 clk = ~clk;

  two_source_arbiter #(.WIDTH(32), .CNT_W(16), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_rdy[0]),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_rdy[0]),
    .out_data(o_data[0]), .out_valid(o_valid[0]), .out_ready(out_ready),
    .out_src(o_src[0]), .cnt_a(c_a[0]), .cnt_b(c_b[0])
  );

  two_source_arbiter #(.WIDTH(32), .CNT_W(16), .RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_rdy[1]),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_rdy[1]),
    .out_data(o_data[1]), .out_valid(o_valid[1]), .out_ready(out_ready),
    .out_src(o_src[1]), .cnt_a(c_a[1]), .cnt_b(c_b[1])
  );

  // Expected grant for instance d: -1 none, 0 A, 1 B.
  function automatic int exp_grant(int d);
    if (m_valid[d] && !out_ready) return -1;
    if (a_valid && b_valid) return (d == 0) ? (1 - int'(m_last[d])) : 0;
    if (a_valid) return 0;
    if (b_valid) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_data[d] = '0; m_valid[d] = 0; m_src[d] = 0; m_last[d] = 1;
      m_cnt_a[d] = 0; m_cnt_b[d] = 0;
    end
  endtask

  // Apply one rising edge to the model using the inputs present at that edge.
  task automatic model_clock();
    for (int d = 0; d < 2; d++) begin
      int g;
      g = exp_grant(d);
      if (g >= 0) begin
        m_data[d]  = (g == 1) ? b_data : a_data;
        m_src[d]   = (g == 1);
        m_valid[d] = 1;
        m_last[d]  = (g == 1);
        if (g == 0) m_cnt_a[d] = (m_cnt_a[d] + 1) % 65536;
        else        m_cnt_b[d] = (m_cnt_b[d] + 1) % 65536;
      end else if (!m_valid[d] || out_ready) begin
        m_valid[d] = 0;
      end
    end
  endtask

  // Reset both instances; returns just after a falling edge.
  task automatic do_reset();
    @(negedge clk);
    a_valid = 0; b_valid = 0; out_ready = 0;
    rst = 1;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (o_valid[d] !== 1'b0 || o_data[d] !== 32'h0 || o_src[d] !== 1'b0 ||
          c_a[d] !== 16'h0 || c_b[d] !== 16'h0)
        $display("FAIL reset_state[%0d] got v=%b d=%h s=%b ca=%h cb=%h want all 0",
                 d, o_valid[d], o_data[d], o_src[d], c_a[d], c_b[d]);
      else passed++;
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_a_only();
    do_reset();
    a_valid = 1; a_data = 32'h1111_1111; out_ready = 1;
    #1;
    total++;
    if (a_rdy[0] !== 1'b1 || b_rdy[0] !== 1'b0)
      $display("FAIL a_only_ready got a=%b b=%b want a=1 b=0", a_rdy[0], b_rdy[0]);
    else passed++;
    @(posedge clk); model_clock(); #1;
    a_valid = 0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (o_valid[d] !== 1'b1 || o_data[d] !== 32'h1111_1111 || o_src[d] !== 1'b0 ||
          c_a[d] !== 16'd1)
        $display("FAIL a_only_out[%0d] got v=%b d=%h s=%b ca=%0d want 1 11111111 0 1",
                 d, o_valid[d], o_data[d], o_src[d], c_a[d]);
      else passed++;
    end
  endtask

  task automatic test_contention();
    bit exp_src [4] = '{0, 1, 0, 1};
    do_reset();
    a_valid = 1; b_valid = 1; a_data = 32'hA0; b_data = 32'hB0; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); model_clock(); #1;
      total++;
      if (o_src[0] !== exp_src[i] || o_data[0] !== (exp_src[i] ? 32'hB0 : 32'hA0))
        $display("FAIL rr_seq[%0d] got src=%b data=%h want src=%b", i, o_src[0], o_data[0], exp_src[i]);
      else passed++;
      total++;
      if (o_src[1] !== 1'b0 || b_rdy[1] !== 1'b0)
        $display("FAIL fixed_seq[%0d] got src=%b b_ready=%b want 0 0", i, o_src[1], b_rdy[1]);
      else passed++;
    end
    a_valid = 0; b_valid = 0;
    total++;
    if (c_a[0] !== 16'd2 || c_b[0] !== 16'd2)
      $display("FAIL rr_counts got a=%0d b=%0d want 2 2", c_a[0], c_b[0]);
    else passed++;
    total++;
    if (c_a[1] !== 16'd4 || c_b[1] !== 16'd0)
      $display("FAIL fixed_counts got a=%0d b=%0d want 4 0", c_a[1], c_b[1]);
    else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    a_valid = 1; b_valid = 1; a_data = 32'h1234_5678; b_data = 32'h9ABC_DEF0; out_ready = 1;
    @(posedge clk); model_clock(); #1;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (a_rdy[0] !== 1'b0 || b_rdy[0] !== 1'b0 || a_rdy[1] !== 1'b0 || b_rdy[1] !== 1'b0)
        $display("FAIL stall_ready[%0d] got rr a=%b b=%b fp a=%b b=%b want all 0",
                 i, a_rdy[0], b_rdy[0], a_rdy[1], b_rdy[1]);
      else passed++;
      @(posedge clk); model_clock(); #1;
      total++;
      if (o_data[0] !== 32'h1234_5678 || o_valid[0] !== 1'b1)
        $display("FAIL stall_hold[%0d] got d=%h v=%b want 12345678 1", i, o_data[0], o_valid[0]);
      else passed++;
    end
    out_ready = 1;
    #1;
    total++;
    if (a_rdy[0] !== 1'b0 || b_rdy[0] !== 1'b1)
      $display("FAIL stall_release_ready got a=%b b=%b want a=0 b=1", a_rdy[0], b_rdy[0]);
    else passed++;
    @(posedge clk); model_clock(); #1;
    a_valid = 0; b_valid = 0;
    total++;
    if (o_valid[0] !== 1'b1 || o_src[0] !== 1'b1 || o_data[0] !== 32'h9ABC_DEF0)
      $display("FAIL stall_release_out got v=%b s=%b d=%h want 1 1 9abcdef0",
               o_valid[0], o_src[0], o_data[0]);
    else passed++;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    b_valid = 1; b_data = 32'hB; out_ready = 1;
    @(posedge clk); model_clock(); #1;
    b_valid = 0; a_valid = 1;
    for (int i = 0; i < 65536; i++) begin
      a_data = i;
      @(posedge clk); model_clock(); #1;
    end
    a_valid = 0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (c_a[d] !== 16'h0000 || c_b[d] !== 16'd1)
        $display("FAIL counter_wrap[%0d] got a=%h b=%h want 0000 0001", d, c_a[d], c_b[d]);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    a_valid = 1; a_data = 32'hDEAD_BEEF; out_ready = 1;
    @(posedge clk); model_clock(); #1;
    a_valid = 0; out_ready = 0;
    #2;
    rst = 1;
    model_reset();
    #1;
    total++;
    if (o_valid[0] !== 1'b0 || o_data[0] !== 32'h0 || c_a[0] !== 16'h0 || c_b[0] !== 16'h0)
      $display("FAIL async_reset got v=%b d=%h ca=%h cb=%h want 0 0 0 0",
               o_valid[0], o_data[0], c_a[0], c_b[0]);
    else passed++;
    a_valid = 1; b_valid = 1; a_data = 32'h5A5A_0001; b_data = 32'h5A5A_0002; out_ready = 1;
    @(negedge clk);
    rst = 0;
    #1;
    total++;
    if (a_rdy[0] !== 1'b1 || b_rdy[0] !== 1'b0)
      $display("FAIL post_reset_grant got a=%b b=%b want 1 0", a_rdy[0], b_rdy[0]);
    else passed++;
    @(posedge clk); model_clock(); #1;
    a_valid = 0; b_valid = 0;
    total++;
    if (o_src[0] !== 1'b0 || o_data[0] !== 32'h5A5A_0001 || o_valid[0] !== 1'b1)
      $display("FAIL post_reset_out got s=%b d=%h v=%b want 0 5a5a0001 1",
               o_src[0], o_data[0], o_valid[0]);
    else passed++;
  endtask

  // Random traffic with full comparison against the model every cycle.
  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      a_valid   = ($urandom_range(0, 3) != 0);
      b_valid   = ($urandom_range(0, 3) != 0);
      a_data    = $urandom;
      b_data    = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      for (int d = 0; d < 2; d++) begin
        int g;
        g = exp_grant(d);
        total++;
        if (a_rdy[d] !== (g == 0) || b_rdy[d] !== (g == 1)) begin
          errs++;
          if (errs < 10)
            $display("FAIL rand_ready[%0d] cyc %0d got a=%b b=%b want grant %0d", d, i, a_rdy[d], b_rdy[d], g);
        end else passed++;
      end
      @(posedge clk); model_clock(); #1;
      for (int d = 0; d < 2; d++) begin
        total++;
        if (o_valid[d] !== m_valid[d] || o_data[d] !== m_data[d] || o_src[d] !== m_src[d] ||
            c_a[d] !== 16'(m_cnt_a[d]) || c_b[d] !== 16'(m_cnt_b[d])) begin
          errs++;
          if (errs < 10)
            $display("FAIL rand_out[%0d] cyc %0d got v=%b d=%h s=%b ca=%0d cb=%0d want v=%b d=%h s=%b ca=%0d cb=%0d",
                     d, i, o_valid[d], o_data[d], o_src[d], c_a[d], c_b[d],
                     m_valid[d], m_data[d], m_src[d], m_cnt_a[d], m_cnt_b[d]);
        end else passed++;
      end
    end
    a_valid = 0; b_valid = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_a_only();
    test_contention();
    test_stall();
    test_async_reset();
    test_random();
    test_counter_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
